// File: rtl/acl_pkg.sv
// acl_pkg: ADXL362 command bytes and sequencer state encodings
package acl_pkg;
    localparam logic [7:0] CMD_WRITE     = 8'h0A;
    localparam logic [7:0] CMD_READ      = 8'h0B;
    localparam logic [7:0] REG_POWER_CTL = 8'h2D;
    localparam logic [7:0] REG_XDATA_L   = 8'h0E;
    localparam logic [7:0] PWR_MEASURE   = 8'h02;
    localparam logic [2:0] S_WAIT_PWR = 3'd0;
    localparam logic [2:0] S_CFG      = 3'd1;
    localparam logic [2:0] S_GAP      = 3'd2;
    localparam logic [2:0] S_IDLE     = 3'd3;
    localparam logic [2:0] S_READ     = 3'd4;
    localparam logic [2:0] S_UPDATE   = 3'd5;
endpackage

// File: rtl/acl_spi_reader_if.sv
// acl_spi_reader_if: SPI pins plus the packed sample output of the reader
interface acl_spi_reader_if;
    logic        miso;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic [14:0] acl_data;
    logic        acl_valid;
    modport master (input miso, output sclk, mosi, cs_n, acl_data, acl_valid);
    modport slave  (output miso, input sclk, mosi, cs_n, acl_data, acl_valid);
endinterface

// File: rtl/acl_spi_shifter.sv
// acl_spi_shifter: mode-0 SPI byte engine; one cs_n window, bytes back to back until last_i
module acl_spi_shifter #(
    parameter int CLK_DIV_HALF = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    input  logic       last_i,
    input  logic       miso_i,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       cs_n_o,
    output logic       byte_done_o,
    output logic [7:0] rx_byte_o,
    output logic       done_o
);
    localparam int CW = $clog2(CLK_DIV_HALF + 1);
    logic          act_q, sclk_q, fin_q, tail_q, tick;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    tx_q;
    logic [6:0]    rx_q;
    assign tick        = act_q && cnt_q == CW'(CLK_DIV_HALF - 1);
    assign byte_done_o = tick && !tail_q && !sclk_q && bit_q == 3'd7;
    assign rx_byte_o   = {rx_q, miso_i};
    assign done_o      = tick && tail_q;
    assign sclk_o      = sclk_q;
    assign mosi_o      = tx_q[7];
    assign cs_n_o      = !act_q;
    // half-period ticks: rising edges sample miso, falling edges advance mosi, a final low half closes cs_n
    always_ff @(posedge clk) begin
        if (rst) begin
            act_q  <= 1'b0;
            sclk_q <= 1'b0;
            fin_q  <= 1'b0;
            tail_q <= 1'b0;
            cnt_q  <= '0;
            bit_q  <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else if (start_i && !act_q) begin
            act_q  <= 1'b1;
            sclk_q <= 1'b0;
            fin_q  <= 1'b0;
            tail_q <= 1'b0;
            cnt_q  <= '0;
            bit_q  <= '0;
            tx_q   <= tx_byte_i;
        end else if (act_q) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (tick && tail_q) begin
                act_q  <= 1'b0;
                tail_q <= 1'b0;
            end else if (tick && !sclk_q) begin
                sclk_q <= 1'b1;
                rx_q   <= {rx_q[5:0], miso_i};
                bit_q  <= bit_q + 1'b1;
                fin_q  <= bit_q == 3'd7 ? last_i : fin_q;
            end else if (tick) begin
                sclk_q <= 1'b0;
                tail_q <= fin_q;
                tx_q   <= fin_q ? 8'h00 : bit_q == 3'd0 ? tx_byte_i : {tx_q[6:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/acl_spi_reader.sv
// acl_spi_reader: configures an ADXL362 once, then samples X/Y/Z periodically into 5-bit fields
module acl_spi_reader #(
    parameter int CLK_DIV_HALF   = 50,
    parameter int STARTUP_CYCLES = 600_000,
    parameter int SAMPLE_CYCLES  = 1_000_000
) (
    input logic              clk,
    input logic              rst,
    acl_spi_reader_if.master bus
);
    import acl_pkg::*;
    localparam int TW = $clog2(STARTUP_CYCLES + 2 * CLK_DIV_HALF + 1);
    localparam int SW = $clog2(SAMPLE_CYCLES + 1);
    logic [2:0]    st_q, st_d, bcnt_q;
    logic [TW-1:0] tmr_q;
    logic [SW-1:0] smp_q;
    logic [14:0]   sh_q, data_q;
    logic [7:0]    tx_byte, rx_byte;
    logic          run_q, valid_q, start, byte_done, done, is_rd, last, gap_done, unused_bits;
    assign is_rd    = st_q == S_IDLE || st_q == S_READ;
    assign start    = (st_q == S_WAIT_PWR && tmr_q == TW'(STARTUP_CYCLES - 1)) || (st_q == S_IDLE && smp_q == '0);
    assign gap_done = tmr_q == TW'(2 * CLK_DIV_HALF - 1);
    assign last     = bcnt_q == (is_rd ? 3'd7 : 3'd2);
    assign tx_byte  = bcnt_q == 3'd0 ? (is_rd ? CMD_READ : CMD_WRITE) :
                      bcnt_q == 3'd1 ? (is_rd ? REG_XDATA_L : REG_POWER_CTL) :
                      (is_rd ? 8'h00 : PWR_MEASURE);
    assign unused_bits   = ^rx_byte[6:4];
    assign bus.acl_data  = data_q;
    assign bus.acl_valid = valid_q;
    acl_spi_shifter #(.CLK_DIV_HALF(CLK_DIV_HALF)) u_shifter (
        .clk(clk),
        .rst(rst),
        .start_i(start),
        .tx_byte_i(tx_byte),
        .last_i(last),
        .miso_i(bus.miso),
        .sclk_o(bus.sclk),
        .mosi_o(bus.mosi),
        .cs_n_o(bus.cs_n),
        .byte_done_o(byte_done),
        .rx_byte_o(rx_byte),
        .done_o(done)
    );
    // sequencing: power-up wait, single config write, then gap-separated periodic reads
    always_comb begin
        st_d = st_q;
        case (st_q)
            S_WAIT_PWR: st_d = start ? S_CFG : S_WAIT_PWR;
            S_CFG:      st_d = done ? S_GAP : S_CFG;
            S_GAP:      st_d = gap_done ? S_IDLE : S_GAP;
            S_IDLE:     st_d = start ? S_READ : S_IDLE;
            S_READ:     st_d = done ? S_UPDATE : S_READ;
            S_UPDATE:   st_d = S_GAP;
            default:    st_d = S_WAIT_PWR;
        endcase
    end
    // state, shared wait/gap timer, free-running sample timer (armed by the first read) and byte counter
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= S_WAIT_PWR;
            tmr_q  <= '0;
            smp_q  <= '0;
            run_q  <= 1'b0;
            bcnt_q <= '0;
        end else begin
            st_q   <= st_d;
            tmr_q  <= ((st_q == S_WAIT_PWR || st_q == S_GAP) && st_d == st_q) ? tmr_q + 1'b1 : '0;
            smp_q  <= ((start && st_q == S_IDLE) || (run_q && smp_q == '0)) ? SW'(SAMPLE_CYCLES - 1) :
                      run_q ? smp_q - 1'b1 : '0;
            run_q  <= run_q || (start && st_q == S_IDLE);
            bcnt_q <= (st_q == S_CFG || st_q == S_READ) ? bcnt_q + 3'(byte_done) : '0;
        end
    end
    // shadow fields keep value12[11:7] = {H[3:0], L[7]} per axis while bytes arrive
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else if (byte_done && st_q == S_READ) begin
            case (bcnt_q)
                3'd2:    sh_q[10]    <= rx_byte[7];
                3'd3:    sh_q[14:11] <= rx_byte[3:0];
                3'd4:    sh_q[5]     <= rx_byte[7];
                3'd5:    sh_q[9:6]   <= rx_byte[3:0];
                3'd6:    sh_q[0]     <= rx_byte[7];
                3'd7:    sh_q[4:1]   <= rx_byte[3:0];
                default: ;
            endcase
        end
    end
    // publish the whole sample at once with a one-cycle valid
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= st_q == S_UPDATE ? sh_q : data_q;
            valid_q <= st_q == S_UPDATE;
        end
    end
endmodule

// File: doc/acl_spi_reader.md
ACL_SPI_READER -- requirements
Module: acl_spi_reader

Interface
REQ-001 SHALL have parameter CLK_DIV_HALF, default 50, the number of clk cycles per SCLK half-period (1 MHz SCLK at 100 MHz clk).
REQ-002 SHALL have parameter STARTUP_CYCLES, default 600_000, the power-up wait before configuration (6 ms).
REQ-003 SHALL have parameter SAMPLE_CYCLES, default 1_000_000, the period between read transactions (100 Hz).
REQ-004 SHALL have port clk  input  1  100 MHz system clock.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high, sampled on clk.
REQ-006 SHALL have port miso  input  1  SPI data from the accelerometer.
REQ-007 SHALL have port sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-008 SHALL have port mosi  output  1  SPI data to the accelerometer, MSB first.
REQ-009 SHALL have port cs_n  output  1  active-low chip select.
REQ-010 SHALL have port acl_data  output  15  packed signed sample: [14:10]=X, [9:5]=Y, [4:0]=Z.
REQ-011 SHALL have port acl_valid  output  1  one-cycle pulse when acl_data updates.

Function
REQ-012 SHALL implement the states WAIT_PWR, CFG, GAP, IDLE, READ and UPDATE.
REQ-013 WAIT_PWR SHALL count STARTUP_CYCLES cycles, then go to CFG.
REQ-014 CFG SHALL be one transaction of 3 bytes: 0x0A (write), 0x2D (POWER_CTL), 0x02 (measure); it then goes to GAP.
REQ-015 READ SHALL be one transaction of 8 bytes: 0x0B (read), 0x0E (XDATA_L), then 6 bytes clocked in as X_L, X_H, Y_L, Y_H, Z_L, Z_H; mosi SHALL be 0 during the read bytes.
REQ-016 Transaction framing: cs_n falls and mosi presents bit 7 in the same cycle; sclk stays low for CLK_DIV_HALF cycles and then toggles every CLK_DIV_HALF cycles.
REQ-017 mosi SHALL change only on sclk falling edges, and miso SHALL be sampled on sclk rising edges.
REQ-018 Each byte SHALL take 8 SCLK periods with no gap between bytes; cs_n SHALL stay low for the whole transaction.
REQ-019 cs_n SHALL rise CLK_DIV_HALF cycles after the final sclk falling edge, and sclk SHALL be low whenever cs_n is high.
REQ-020 GAP SHALL hold cs_n high for at least 2*CLK_DIV_HALF cycles between transactions.
REQ-021 In IDLE, a free-running sample timer SHALL start a READ every SAMPLE_CYCLES cycles, measured cs_n fall to cs_n fall.
REQ-022 If a READ has not finished when the timer expires, that start SHALL be skipped; no queueing.
REQ-023 Data reduction SHALL be per axis: value12 = {H[3:0], L[7:0]}, output field = value12[11:7] (arithmetic shift right by 7, no rounding, no saturation).
REQ-024 UPDATE SHALL load all three fields into acl_data in a single cycle and pulse acl_valid high for that one cycle.
REQ-025 acl_data SHALL never show a partially updated sample, and SHALL hold its value between updates.
REQ-026 There SHALL be no retry and no error detection; CFG SHALL run exactly once after each reset.

Reset
REQ-027 On rst: cs_n=1, sclk=0, mosi=0, acl_data=0, acl_valid=0, state=WAIT_PWR, and all counters cleared.
REQ-028 rst asserted mid-transaction SHALL abort it: cs_n=1 and sclk=0 on the next cycle, no acl_valid pulse, and the full startup plus CFG sequence repeats.
REQ-029 Reset SHALL take priority over all other events in the same cycle.

Structure
REQ-030 Package acl_pkg SHALL hold CMD_WRITE=0x0A, CMD_READ=0x0B, REG_POWER_CTL=0x2D, REG_XDATA_L=0x0E, PWR_MEASURE=0x02 and the state enumeration.
REQ-031 One sub-module, acl_spi_shifter, SHALL generate SCLK, handle the byte shift in and out, and give a byte-done strobe.
REQ-032 The top level SHALL hold the sequencing FSM, the byte counter, the timers and the output packing.

Verification
REQ-033 All scenarios SHALL use CLK_DIV_HALF=2, STARTUP_CYCLES=20, SAMPLE_CYCLES=400, and an ADXL362 behavioural model.
REQ-034 Reset, hold 5 cycles -> cs_n=1, sclk=0, mosi=0, acl_data=0x0000, acl_valid=0, and cs_n falls exactly 20 cycles after rst is released.
REQ-035 First transaction -> model captures 24 bits 0x0A, 0x2D, 0x02 on rising edges, each cs_n low window is exactly (bytes*8*2+1)*CLK_DIV_HALF cycles (3-byte CFG: 98, 8-byte READ: 258), and cs_n stays high at least 4 cycles afterwards.
REQ-036 Model returns X=0x0400, Y=0xFE00, Z=0x0000 -> acl_data=0x2380 with exactly one acl_valid pulse after the 64th sclk rising edge.
REQ-037 Model returns X=0x07FF, Y=0xF800, Z=0xFF80 -> acl_data fields 01111, 10000, 11111 (0x3E1F).
REQ-038 Steady state -> consecutive READ cs_n falls are 400 cycles apart, mosi is 0 during read bytes, and acl_data is stable between pulses.
REQ-039 rst asserted during the 4th byte of a READ -> next cycle cs_n=1, sclk=0, acl_data=0, no acl_valid pulse, and CFG bytes reappear after 20 cycles.
